serial_magnitude_comparator: RTL and testbench



---
 rtl/serial_magnitude_comparator_pkg.sv | 14 +
 rtl/serial_magnitude_comparator_onebit.sv | 17 +
 rtl/serial_magnitude_comparator.sv | 102 ++++++++++
 tb/tb_serial_magnitude_comparator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and defaults for the serial magnitude comparator.
package serial_magnitude_comparator_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;

endpackage

// File: rtl/serial_magnitude_comparator_onebit.sv
// Purely combinational single-bit magnitude comparator.
module onebit_comparator (
    input  logic a,
    input  logic b,
    output logic agb,
    output logic eg,
    output logic alb
);

    // Exactly one of the three flags is high for any input pair
    always_comb begin
        agb = a & ~b;
        alb = ~a & b;
        eg  = ~(a ^ b);
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Serial MSB-first unsigned magnitude comparator built around one
// onebit_comparator; stops at the first differing bit.
module serial_magnitude_comparator
    import serial_magnitude_comparator_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             agb,
    output logic             eg,
    output logic             alb,
    output logic [CNT_W-1:0] bits_used
);

    state_t             state;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [CNT_W-1:0]   cnt;
    logic               cmp_agb;
    logic               cmp_eg;
    logic               cmp_alb;

    onebit_comparator u_bit (
        .a   (a_sh[WIDTH-1]),
        .b   (b_sh[WIDTH-1]),
        .agb (cmp_agb),
        .eg  (cmp_eg),
        .alb (cmp_alb)
    );

    // Sequencer: operand capture, MSB-first scan, registered verdict
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            agb       <= 1'b0;
            eg        <= 1'b0;
            alb       <= 1'b0;
            bits_used <= '0;
        end else begin
            case (state)
                // DONE accepts a new start exactly like IDLE (back-to-back)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh      <= a_in;
                        b_sh      <= b_in;
                        cnt       <= CNT_W'(WIDTH);
                        agb       <= 1'b0;
                        eg        <= 1'b0;
                        alb       <= 1'b0;
                        bits_used <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SCAN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    bits_used <= bits_used + CNT_W'(1);
                    if (cmp_agb) begin
                        agb   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else if (cmp_alb) begin
                        alb   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else if (cmp_eg && cnt == CNT_W'(1)) begin
                        eg    <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                        b_sh <= {b_sh[WIDTH-2:0], 1'b0};
                        cnt  <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator (WIDTH=8).
module tb_serial_magnitude_comparator;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  b_in = '0;
    logic          busy, done, agb, eg, alb;
    logic [CW-1:0] bits_used;

    serial_magnitude_comparator #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .agb       (agb),
        .eg        (eg),
        .alb       (alb),
        .bits_used (bits_used)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] v;        // {agb, eg, alb}
        int         k;        // bits examined
        int         done_at;  // cycle number at which done is seen
    } exp_t;

    exp_t q[$];
    int   cyc = 1;
    int   free_at = 0;
    int   busy_until = 0;
    int   acc_cyc = 0;
    int   n_acc = 0;
    logic [2:0] last_v = 3'b000;
    int   last_k = 0;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: bits examined = position of the highest differing bit from the top
    function automatic int calc_k(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        x = a ^ b;
        for (int i = W - 1; i >= 0; i--)
            if (x[i]) return W - i;
        return W;
    endfunction

    function automatic logic [2:0] calc_v(input logic [W-1:0] a, input logic [W-1:0] b);
        if (a > b) return 3'b100;
        if (a == b) return 3'b010;
        return 3'b001;
    endfunction

    // Model: decide acceptance of each sampled start and push the expected verdict
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            free_at = 0;
            busy_until = 0;
        end else if (start && cyc >= free_at) begin
            exp_t e;
            e.v = calc_v(a_in, b_in);
            e.k = calc_k(a_in, b_in);
            e.done_at = cyc + e.k + 1;
            q.push_back(e);
            acc_cyc = cyc;
            busy_until = cyc + e.k;
            free_at = cyc + e.k + 1;
            n_acc++;
        end
        cyc++;
    end

    // Monitor: compare DUT outputs against the scoreboard each falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            logic       exp_done, exp_busy;
            logic [2:0] exp_v;
            int         exp_bits;
            exp_done = (q.size() > 0) && (q[0].done_at == cyc);
            exp_busy = !exp_done && (cyc <= busy_until);
            if (exp_done) begin
                exp_v = q[0].v;
                exp_bits = q[0].k;
            end else if (exp_busy) begin
                exp_v = 3'b000;
                exp_bits = cyc - acc_cyc - 1;
            end else begin
                exp_v = last_v;
                exp_bits = last_k;
            end
            chk("done", int'(done), int'(exp_done));
            chk("busy", int'(busy), int'(exp_busy));
            chk("verdict", int'({agb, eg, alb}), int'(exp_v));
            chk("bits_used", int'(bits_used), exp_bits);
            if (exp_done) begin
                last_v = q[0].v;
                last_k = q[0].k;
                void'(q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q.size() > 0 || cyc <= free_at) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            total++;
            bad++;
            $display("FAIL drain_timeout at cycle %0d: got pending=%0d expected 0", cyc, q.size());
        end
    endtask

    task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        a_in = a;
        b_in = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    // Hold start high through two accepts, switching operands after the first
    task automatic two_held(input logic [W-1:0] a0, input logic [W-1:0] b0,
                            input logic [W-1:0] a1, input logic [W-1:0] b1);
        int base;
        int n;
        base = n_acc;
        @(negedge clk);
        a_in = a0;
        b_in = b0;
        start = 1'b1;
        @(negedge clk);
        a_in = a1;
        b_in = b1;
        n = 0;
        while (n_acc < base + 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_count", n_acc - base, 2);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #1;
        chk("rst_flags", int'({busy, done, agb, eg, alb}), 0);
        chk("rst_bits", int'(bits_used), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a scan discards the comparison
        @(negedge clk);
        a_in = 8'h55;
        b_in = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b0;
        q.delete();
        free_at = 0;
        busy_until = 0;
        last_v = 3'b000;
        last_k = 0;
        #1;
        chk("midscan_rst_flags", int'({busy, done, agb, eg, alb}), 0);
        chk("midscan_rst_bits", int'(bits_used), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        do_cmp(8'h01, 8'h00);

        // Directed boundary cases
        do_cmp(8'h80, 8'h7F);
        do_cmp(8'h12, 8'h13);
        do_cmp(8'hA5, 8'hA5);
        do_cmp(8'h00, 8'h00);
        do_cmp(8'hFF, 8'hFF);

        // Start during scan is ignored, held start taken in DONE
        two_held(8'h0F, 8'h0E, 8'h00, 8'hFF);

        // Back-to-back with start held, then verdict hold
        two_held(8'h40, 8'h20, 8'h20, 8'h40);
        repeat (20) @(negedge clk);

        // Random start pattern and operands sharing random-length prefixes
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) != 0);
            a_in = W'($urandom);
            case ($urandom_range(0, 3))
                0: b_in = a_in;
                1: b_in = W'($urandom);
                default: b_in = a_in ^ (W'(1) << $urandom_range(0, W - 1));
            endcase
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
